fpu_operand_loader: RTL and testbench

- Upstream stage of the custom-format FPU adder.
- Accepts IEEE-754 binary32 words over a valid/ready stream, alternating operand A then operand B.
- Converts each word to the team float format: [31] sign, [30:25] exponent with bias 31, [24:0] mantissa with implicit leading 1.
- Presents the converted pair to the adder's operand inputs together, then holds it stable for a programmable number of cycles so the adder completes its pass on a consistent pair.

---
 rtl/fpu_operand_loader_if.sv | 22 ++
 rtl/fpu_operand_loader.sv | 139 +++++++++++++
 tb/tb_fpu_operand_loader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_operand_loader_if.sv
// Operand-loader bus: binary32 input stream (valid/ready) plus the converted pair toward the FPU adder.
// Pure wiring, no latency; in_ready is the only backpressure and is driven by the loader.
interface fpu_operand_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] op_A_out;
  logic [31:0] op_B_out;
  logic        op_valid;
  logic        busy;
  logic [3:0]  flags_out;

  modport master (
    output in_valid, in_data,
    input  in_ready, op_A_out, op_B_out, op_valid, busy, flags_out
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, op_A_out, op_B_out, op_valid, busy, flags_out
  );
endinterface

// File: rtl/fpu_operand_loader.sv
// Converts binary32 A/B word pairs to the team float format and commits them to the adder together.
// Pair commits on the B-accept edge; in_ready then stays low for HOLD_CYCLES cycles while the pair is held.
module fpu_operand_loader #(
  parameter int HOLD_CYCLES = 32
) (
  input logic                  clock,
  input logic                  reset,
  fpu_operand_loader_if.slave  bus
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [1:0] LOAD_A = 2'd0;
  localparam logic [1:0] LOAD_B = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  typedef struct packed {
    logic        over;
    logic        under;
    logic [31:0] val;
  } conv_t;

  // Exponent field 0 is reserved for zero, so the representable binary32 range is e = 97..159.
  function automatic conv_t convert(input logic [31:0] w);
    conv_t       r;
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [7:0]  re;
    s       = w[31];
    e       = w[30:23];
    m       = w[22:0];
    re      = e - 8'd96;
    r.over  = 1'b0;
    r.under = 1'b0;
    r.val   = {s, 31'b0};
    if (e == 8'd0) begin
      r.under = (m != 23'd0);
    end else if (e >= 8'd160) begin
      r.over = 1'b1;
      r.val  = {s, 6'h3F, 25'h1FFFFFF};
    end else if (e <= 8'd96) begin
      r.under = 1'b1;
    end else begin
      r.val = {s, re[5:0], m, 2'b00};
    end
    return r;
  endfunction

  logic [1:0]       state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [31:0]      a_shadow_q, a_shadow_d;
  logic [1:0]       a_flags_q,  a_flags_d;
  logic [31:0]      op_a_q,     op_a_d;
  logic [31:0]      op_b_q,     op_b_d;
  logic [3:0]       flags_q,    flags_d;
  logic             op_valid_q, op_valid_d;

  conv_t in_conv;
  logic  in_ready;
  logic  xfer;

  always_comb begin
    in_conv  = convert(bus.in_data);
    in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
    xfer     = bus.in_valid && in_ready;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_shadow_d = a_shadow_q;
    a_flags_d  = a_flags_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    flags_d    = flags_q;
    op_valid_d = 1'b0;
    case (state_q)
      LOAD_A: begin
        if (xfer) begin
          a_shadow_d = in_conv.val;
          a_flags_d  = {in_conv.over, in_conv.under};
          state_d    = LOAD_B;
        end
      end
      LOAD_B: begin
        // Both operands land on the same edge so the adder never sees a mixed pair.
        if (xfer) begin
          op_a_d     = a_shadow_q;
          op_b_d     = in_conv.val;
          flags_d    = {in_conv.over, in_conv.under, a_flags_q};
          op_valid_d = 1'b1;
          cnt_d      = CNT_RELOAD;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = LOAD_A;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= LOAD_A;
      cnt_q      <= '0;
      a_shadow_q <= '0;
      a_flags_q  <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      flags_q    <= '0;
      op_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_shadow_q <= a_shadow_d;
      a_flags_q  <= a_flags_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      flags_q    <= flags_d;
      op_valid_q <= op_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = (state_q == HOLD);
  assign bus.op_A_out  = op_a_q;
  assign bus.op_B_out  = op_b_q;
  assign bus.op_valid  = op_valid_q;
  assign bus.flags_out = flags_q;

endmodule

// File: tb/tb_fpu_operand_loader.sv
// Directed and randomized pairs against an arithmetic reference of the binary32 -> team-format conversion.
module tb_fpu_operand_loader;

  localparam int HC    = 32;
  localparam int BOUND = 200;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   pulses[$];

  logic [31:0] exp_a = '0;
  logic [31:0] exp_b = '0;
  logic [3:0]  exp_f = '0;

  fpu_operand_loader_if bus ();
  fpu_operand_loader_if bus1 ();

  fpu_operand_loader #(.HOLD_CYCLES(HC)) dut (.clock(clock), .reset(reset), .bus(bus));
  fpu_operand_loader #(.HOLD_CYCLES(1))  dut1 (.clock(clock), .reset(reset), .bus(bus1));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (reset && bus.op_valid) pulses.push_back(cyc);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: unbias, rebias to 31, then range-check against the 6-bit field (1..63).
  function automatic void ref_conv(input logic [31:0] w, output logic [31:0] v,
                                   output logic ov, output logic un);
    int e  = int'(w[30:23]);
    int te = e - 127 + 31;
    ov = 1'b0;
    un = 1'b0;
    v  = {w[31], 31'b0};
    if (e == 0) begin
      un = (w[22:0] != 0);
    end else if (e == 255 || te > 63) begin
      ov = 1'b1;
      v  = {w[31], 6'h3F, 25'h1FFFFFF};
    end else if (te < 1) begin
      un = 1'b1;
    end else begin
      v = {w[31], 6'(te), w[22:0], 2'b00};
    end
  endfunction

  function automatic logic [31:0] rand_word();
    logic [7:0] e;
    case ($urandom_range(0, 3))
      0:       e = 8'($urandom_range(90, 166));
      1:       e = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
      default: e = 8'($urandom);
    endcase
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic push(input logic [31:0] w, input bit keep);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!bus.in_ready && n < BOUND) begin
      @(negedge clock);
      n++;
    end
    check("accept_timeout", 32'(n < BOUND), 32'd1);
    @(negedge clock);
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic commit_check(input logic [31:0] a, input logic [31:0] b);
    logic oa, ua, ob, ub;
    ref_conv(a, exp_a, oa, ua);
    ref_conv(b, exp_b, ob, ub);
    exp_f = {ob, ub, oa, ua};
    check("commit_valid", bus.op_valid, 1);
    check("commit_opA", bus.op_A_out, exp_a);
    check("commit_opB", bus.op_B_out, exp_b);
    check("commit_flags", bus.flags_out, exp_f);
    check("commit_busy", bus.busy, 1);
    check("commit_ready", bus.in_ready, 0);
  endtask

  task automatic hold_check();
    int cnt = 0;
    while (!bus.in_ready && cnt < BOUND) begin
      check("hold_valid", bus.op_valid, 32'(cnt == 0));
      check("hold_opA", bus.op_A_out, exp_a);
      check("hold_opB", bus.op_B_out, exp_b);
      @(negedge clock);
      cnt++;
    end
    check("hold_len", cnt, HC);
    check("post_busy", bus.busy, 0);
    check("post_flags", bus.flags_out, exp_f);
  endtask

  task automatic do_pair(input logic [31:0] a, input logic [31:0] b, input int gap,
                         input bit b2b, input logic [31:0] nxt);
    push(a, gap == 0);
    for (int i = 0; i < gap; i++) begin
      check("stall_ready", bus.in_ready, 1);
      check("stall_valid", bus.op_valid, 0);
      check("stall_opA", bus.op_A_out, exp_a);
      check("stall_opB", bus.op_B_out, exp_b);
      @(negedge clock);
    end
    push(b, b2b);
    if (b2b) bus.in_data = nxt;
    commit_check(a, b);
    hold_check();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_opA"}, bus.op_A_out, 0);
    check({tag, "_opB"}, bus.op_B_out, 0);
    check({tag, "_flags"}, bus.flags_out, 0);
    check({tag, "_valid"}, bus.op_valid, 0);
    check({tag, "_ready"}, bus.in_ready, 1);
    check({tag, "_busy"}, bus.busy, 0);
    exp_a = '0;
    exp_b = '0;
    exp_f = '0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus1.in_valid = 1'b0;
    bus1.in_data  = '0;
    repeat (2) @(negedge clock);
    check_zero("reset");
    check("reset1_ready", bus1.in_ready, 1);
    check("reset1_busy", bus1.busy, 0);
    reset = 1'b1;
    @(negedge clock);

    do_pair(32'h3F800000, 32'h40000000, 0, 1'b0, '0);
    check("basic_opA", bus.op_A_out, 32'h3E000000);
    check("basic_opB", bus.op_B_out, 32'h40000000);
    check("basic_flags", bus.flags_out, 0);

    do_pair(32'h3FC00000, 32'hBFC00000, 0, 1'b0, '0);
    check("sign_opA", bus.op_A_out, 32'h3F000000);
    check("sign_opB", bus.op_B_out, 32'hBF000000);

    do_pair(32'h4F800000, 32'hD0000000, 0, 1'b0, '0);
    check("e159_opA", bus.op_A_out, 32'h7E000000);
    check("e160_opB", bus.op_B_out, 32'hFFFFFFFF);
    check("e160_flags", bus.flags_out, 32'h8);

    do_pair(32'h30800000, 32'h30000000, 5, 1'b0, '0);
    check("e97_opA", bus.op_A_out, 32'h02000000);
    check("e96_opB", bus.op_B_out, 32'h00000000);
    check("e96_flags", bus.flags_out, 32'h4);

    do_pair(32'h80000000, 32'h00000001, 0, 1'b0, '0);
    check("negzero_opA", bus.op_A_out, 32'h80000000);
    check("denorm_flags", bus.flags_out, 32'h4);

    do_pair(32'h7F800000, 32'h7FC00000, 0, 1'b0, '0);
    check("inf_opA", bus.op_A_out, 32'h7FFFFFFF);
    check("nan_opB", bus.op_B_out, 32'h7FFFFFFF);
    check("infnan_flags", bus.flags_out, 32'hA);

    // Three pairs with in_valid never dropping; the next A sits on the bus through each HOLD.
    pulses.delete();
    do_pair(32'h3F800000, 32'h40400000, 0, 1'b1, 32'hC0800000);
    do_pair(32'hC0800000, 32'h41200000, 0, 1'b1, 32'h3E800000);
    do_pair(32'h3E800000, 32'h42C80000, 0, 1'b0, '0);
    @(negedge clock);
    check("b2b_pulses", pulses.size(), 3);
    if (pulses.size() == 3) begin
      check("b2b_gap1", pulses[1] - pulses[0], HC + 2);
      check("b2b_gap2", pulses[2] - pulses[1], HC + 2);
    end

    // HOLD_CYCLES = 1 instance.
    bus1.in_valid = 1'b1;
    bus1.in_data  = 32'h3F800000;
    check("h1_readyA", bus1.in_ready, 1);
    @(negedge clock);
    bus1.in_data = 32'h40000000;
    @(negedge clock);
    bus1.in_data = 32'h40400000;
    check("h1_valid", bus1.op_valid, 1);
    check("h1_busy", bus1.busy, 1);
    check("h1_ready", bus1.in_ready, 0);
    check("h1_opA", bus1.op_A_out, 32'h3E000000);
    check("h1_opB", bus1.op_B_out, 32'h40000000);
    @(negedge clock);
    bus1.in_valid = 1'b0;
    check("h1_ready_back", bus1.in_ready, 1);
    check("h1_busy_low", bus1.busy, 0);
    check("h1_valid_low", bus1.op_valid, 0);

    // Reset with A staged: A is discarded.
    push(32'h3F800000, 1'b0);
    reset = 1'b0;
    #1;
    check_zero("midpair_rst");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    do_pair(32'h40000000, 32'h3F800000, 0, 1'b0, '0);
    check("midpair_opA", bus.op_A_out, 32'h40000000);
    check("midpair_opB", bus.op_B_out, 32'h3E000000);

    // Reset during HOLD clears outputs without waiting for a clock edge.
    push(32'h3FC00000, 1'b1);
    push(32'h40000000, 1'b0);
    commit_check(32'h3FC00000, 32'h40000000);
    repeat (5) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_zero("hold_rst");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    for (int k = 0; k < 20; k++) begin
      logic [31:0] wa;
      logic [31:0] wb;
      wa = rand_word();
      wb = rand_word();
      do_pair(wa, wb, $urandom_range(0, 3), 1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
